matmul_tile_buffer_ctrl: RTL and testbench
==========================================

Name: matmul_tile_buffer_ctrl

Overview:
Parametrised on-chip buffer and sequencing block placed between the host programming interface and an R x C grid of systolic matmul tiles.
- Holds NUM_ROWS A banks, NUM_COLS B banks and NUM_ROWS C banks.
- Arbitrates host load/readback against engine access with a state machine; host and engine never share a bank port in the same phase.
- Captures per-row C output streams through per-row write pointers and reports completion and errors.
- Generalises the fixed 2-bank A/B/C wrapper to any grid size and adds proper sequencing, C capture, error flags and a host read-valid handshake.

Parameters:
DWIDTH, 8, element width in bits
BB_SIZE, 32, elements per memory word; word width W = BB_SIZE*DWIDTH
AWIDTH, 7, bank address width; depth = 2**AWIDTH
NUM_ROWS, 2, A banks and C banks (tile grid rows)
NUM_COLS, 2, B banks (tile grid columns)
SELW, 4, bank-select width; must satisfy 2**SELW >= max(NUM_ROWS, NUM_COLS)

Ports:
clk  in  1  single clock for all logic and memories
reset  in  1  synchronous, active-high
host_wr_en  in  1  host write strobe
host_wr_mat  in  2  target matrix: 0=A, 1=B, 2/3 illegal
host_bank  in  SELW  bank index, shared by host writes and reads
host_addr  in  AWIDTH  word address, shared by host writes and reads
host_wdata  in  W  write data
host_rd_req  in  1  C readback request
host_rd_valid  out  1  readback data valid
host_rd_data  out  W  readback data
start  in  1  begin a multiply
eng_start  out  1  one-cycle start pulse to the tile grid
eng_done  in  1  completion pulse from the tile grid
eng_a_addr  in  NUM_ROWS*AWIDTH  per-row A read addresses
eng_a_data  out  NUM_ROWS*W  per-row A read data
eng_b_addr  in  NUM_COLS*AWIDTH  per-column B read addresses
eng_b_data  out  NUM_COLS*W  per-column B read data
eng_c_valid  in  NUM_ROWS  per-row C word strobe
eng_c_data  in  NUM_ROWS*W  per-row C words
busy  out  1  high in RUN and FINISH
done  out  1  one-cycle completion pulse
err_flags  out  3  sticky: [0] host access blocked or illegal, [1] C overflow, [2] start while busy

Behaviour:
- Reset (sync, active-high) clears the following, effective the next cycle, from any state including mid-RUN: state to IDLE, all outputs to 0, C write pointers, err_flags, and pipeline registers. Memory contents are retained and not cleared.
- States:
  - IDLE: host writes and host reads are serviced. start=1 -> RUN and eng_start=1 in the same edge's output cycle; C pointers zeroed.
  - RUN: engine owns all ports. eng_done=1 -> FINISH.
  - FINISH: one cycle; done=1, then -> IDLE.
  - busy=1 in RUN and FINISH.
- Host write:
  - In IDLE with a legal mat/bank, the word is written on the same edge.
  - Illegal cases: mat>=2, bank>=NUM_ROWS for A, bank>=NUM_COLS for B. These writes are dropped and set err[0].
  - Host writes in RUN/FINISH are dropped and set err[0].
- Host read:
  - In IDLE with host_bank<NUM_ROWS, host_rd_valid=1 with C[bank][addr] exactly 2 cycles after the req (address register, then synchronous RAM read register).
  - Otherwise no valid is produced and err[0] is set.
  - Back-to-back reqs are fully pipelined, one result per cycle.
- Engine read: per bank, eng_*_data reflects mem[addr] 2 cycles after the address is presented (address register, then RAM output register). This path is active in RUN only; outside RUN, eng_*_data holds its last value.
- C capture:
  - In RUN, eng_c_valid[r]=1 writes eng_c_data slice r to C[r][ptr_r], then ptr_r increments.
  - When ptr_r has reached 2**AWIDTH (all entries written), further valids are dropped and set err[1]; there is no wrap.
  - Valids outside RUN are ignored and do not set an error.
- Simultaneous events:
  - start and host_wr_en together in IDLE: the write completes, then RUN begins.
  - start in RUN/FINISH: ignored, sets err[2].
  - eng_done and eng_c_valid in the same cycle: the C word is captured.
  - eng_done while in IDLE: ignored.
- err_flags clear only on reset.

Test Plan:
- Reset then load A bank1 addr5=0xA5.., B bank0 addr3=0x3C..; start; engine drives a_addr[1]=5, b_addr[0]=3 -> eng_a_data slice1 and eng_b_data slice0 match 2 cycles later; eng_start is a single pulse.
- Engine streams 4 valids on row0 and 2 on row1, then eng_done -> done pulse 1 cycle after eng_done, busy falls; host_rd_req bank0 addr0..3 back-to-back -> 4 consecutive valid words, first valid 2 cycles after the first req.
- Host write during RUN and host_wr_mat=2 in IDLE -> memory unchanged (read back shows old value), err_flags=3'b001.
- Drive 2**AWIDTH+1 valids on row0 (129 with AWIDTH=7) -> first 128 stored, err[1]=1, C[0][0] not overwritten.
- start asserted while in RUN -> no second eng_start pulse, err[2]=1; assert reset mid-RUN -> next cycle busy=0, err=0, state IDLE, previously loaded A data still readable by a new run.
- Parameter sweep NUM_ROWS=4, NUM_COLS=3, AWIDTH=4 -> host write to B bank3 rejected (err[0]), A bank3 write/read path and a 16-entry C overflow boundary are correct.

Source files
------------

// File: rtl/matmul_tile_buffer_ctrl.sv
// Buffer and sequencer between the host programming interface and an
// R x C systolic matmul tile grid. Holds one A and one C bank per grid row
// and one B bank per grid column. A three-state controller decides whether
// the host (IDLE) or the engine (RUN) owns the bank ports. Per-row C write
// pointers capture the result streams. Sticky error flags record blocked or
// illegal host accesses, C overflow, and start requests while busy.
module matmul_tile_buffer_ctrl #(
    parameter int DWIDTH   = 8,
    parameter int BB_SIZE  = 32,
    parameter int AWIDTH   = 7,
    parameter int NUM_ROWS = 2,
    parameter int NUM_COLS = 2,
    parameter int SELW     = 4,
    localparam int W       = BB_SIZE * DWIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_wr_en,
    input  logic [1:0]                 host_wr_mat,
    input  logic [SELW-1:0]            host_bank,
    input  logic [AWIDTH-1:0]          host_addr,
    input  logic [W-1:0]               host_wdata,
    input  logic                       host_rd_req,
    output logic                       host_rd_valid,
    output logic [W-1:0]               host_rd_data,
    input  logic                       start,
    output logic                       eng_start,
    input  logic                       eng_done,
    input  logic [NUM_ROWS*AWIDTH-1:0] eng_a_addr,
    output logic [NUM_ROWS*W-1:0]      eng_a_data,
    input  logic [NUM_COLS*AWIDTH-1:0] eng_b_addr,
    output logic [NUM_COLS*W-1:0]      eng_b_data,
    input  logic [NUM_ROWS-1:0]        eng_c_valid,
    input  logic [NUM_ROWS*W-1:0]      eng_c_data,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 err_flags
);
    localparam int            DEPTH = 2 ** AWIDTH;
    localparam logic [SELW:0] NR_L  = (SELW + 1)'(NUM_ROWS);
    localparam logic [SELW:0] NC_L  = (SELW + 1)'(NUM_COLS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t        state_q, state_d;
    logic          eng_start_q, eng_start_d;
    logic [2:0]    err_q, err_d;

    logic          is_idle, is_run;
    logic [SELW:0] bank_ext;
    logic          wr_a_en, wr_b_en, rd_ok;
    logic [NUM_ROWS-1:0] c_ovf;

    // Host read pipeline: stage 1 registers the address, stage 2 the RAM data.
    logic              rd_v1_q, rd_v2_q;
    logic [SELW-1:0]   rd_bank1_q, rd_bank2_q;
    logic [AWIDTH-1:0] rd_addr1_q;
    logic [W-1:0]      c_rd_q [NUM_ROWS];

    assign is_idle  = (state_q == S_IDLE);
    assign is_run   = (state_q == S_RUN);
    assign bank_ext = {1'b0, host_bank};
    assign wr_a_en  = host_wr_en && is_idle && (host_wr_mat == 2'd0) && (bank_ext < NR_L);
    assign wr_b_en  = host_wr_en && is_idle && (host_wr_mat == 2'd1) && (bank_ext < NC_L);
    assign rd_ok    = host_rd_req && is_idle && (bank_ext < NR_L);

    assign busy          = (state_q == S_RUN) || (state_q == S_FINISH);
    assign done          = (state_q == S_FINISH);
    assign eng_start     = eng_start_q;
    assign err_flags     = err_q;
    assign host_rd_valid = rd_v2_q;

    // Controller state, start pulse and sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            eng_start_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            eng_start_q <= eng_start_d;
            err_q       <= err_d;
        end
    end

    // Next-state and start-pulse decode.
    always_comb begin
        state_d     = state_q;
        eng_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    eng_start_d = 1'b1;
                end
            end
            S_RUN:    if (eng_done) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Error accumulation: flags only ever get set until the next reset.
    always_comb begin
        err_d = err_q;
        if ((host_wr_en && !(wr_a_en || wr_b_en)) || (host_rd_req && !rd_ok))
            err_d[0] = 1'b1;
        if (|c_ovf)
            err_d[1] = 1'b1;
        if (start && !is_idle)
            err_d[2] = 1'b1;
    end

    // Host readback address and valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v1_q    <= 1'b0;
            rd_v2_q    <= 1'b0;
            rd_bank1_q <= '0;
            rd_bank2_q <= '0;
            rd_addr1_q <= '0;
        end else begin
            rd_v1_q    <= rd_ok;
            rd_bank1_q <= host_bank;
            rd_addr1_q <= host_addr;
            rd_v2_q    <= rd_v1_q;
            rd_bank2_q <= rd_bank1_q;
        end
    end

    // Select the registered C word of the bank being read back.
    always_comb begin
        host_rd_data = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (rd_bank2_q == SELW'(i))
                host_rd_data = c_rd_q[i];
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [W-1:0]      amem [DEPTH];
        logic [W-1:0]      cmem [DEPTH];
        logic [AWIDTH-1:0] a_addr_q;
        logic [W-1:0]      a_dat_q;
        logic [AWIDTH:0]   ptr_q;
        logic              sel, c_wr;

        assign sel      = (host_bank == SELW'(r));
        // ptr_q[AWIDTH] set means every entry of this C bank has been written.
        assign c_wr     = is_run && eng_c_valid[r] && !ptr_q[AWIDTH];
        assign c_ovf[r] = is_run && eng_c_valid[r] && ptr_q[AWIDTH];
        assign eng_a_data[r*W +: W] = a_dat_q;

        // A bank storage: host write port, usable only in IDLE.
        always_ff @(posedge clk) begin
            if (wr_a_en && sel)
                amem[host_addr] <= host_wdata;
        end

        // A bank engine read: address register then RAM output register, RUN only.
        always_ff @(posedge clk) begin
            if (reset) begin
                a_addr_q <= '0;
                a_dat_q  <= '0;
            end else if (is_run) begin
                a_addr_q <= eng_a_addr[r*AWIDTH +: AWIDTH];
                a_dat_q  <= amem[a_addr_q];
            end
        end

        // C bank storage: engine capture port at the row write pointer.
        always_ff @(posedge clk) begin
            if (c_wr)
                cmem[ptr_q[AWIDTH-1:0]] <= eng_c_data[r*W +: W];
        end

        // C write pointer: cleared when a run starts, saturates once full.
        always_ff @(posedge clk) begin
            if (reset)
                ptr_q <= '0;
            else if (is_idle && start)
                ptr_q <= '0;
            else if (c_wr)
                ptr_q <= ptr_q + (AWIDTH + 1)'(1);
        end

        // C bank host read register, second stage of the readback pipeline.
        always_ff @(posedge clk) begin
            if (reset)
                c_rd_q[r] <= '0;
            else if (rd_v1_q && (rd_bank1_q == SELW'(r)))
                c_rd_q[r] <= cmem[rd_addr1_q];
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        logic [W-1:0]      bmem [DEPTH];
        logic [AWIDTH-1:0] b_addr_q;
        logic [W-1:0]      b_dat_q;
        logic              sel;

        assign sel = (host_bank == SELW'(c));
        assign eng_b_data[c*W +: W] = b_dat_q;

        // B bank storage: host write port, usable only in IDLE.
        always_ff @(posedge clk) begin
            if (wr_b_en && sel)
                bmem[host_addr] <= host_wdata;
        end

        // B bank engine read: address register then RAM output register, RUN only.
        always_ff @(posedge clk) begin
            if (reset) begin
                b_addr_q <= '0;
                b_dat_q  <= '0;
            end else if (is_run) begin
                b_addr_q <= eng_b_addr[c*AWIDTH +: AWIDTH];
                b_dat_q  <= bmem[b_addr_q];
            end
        end
    end

endmodule

// File: tb/tb_matmul_tile_buffer_ctrl.sv
// Self-checking bench for matmul_tile_buffer_ctrl: a default 2x2 instance and
// a 4x3 instance with a 16-deep bank. Host readback results go through a
// scoreboard that holds each expected word and the cycle it is due.
module tb_matmul_tile_buffer_ctrl;
    localparam int W   = 256;
    localparam int AW  = 7;
    localparam int NR  = 2;
    localparam int NC  = 2;
    localparam int SW  = 4;
    localparam int AW1 = 4;
    localparam int NR1 = 4;
    localparam int NC1 = 3;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc_n = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;

    logic             reset;
    logic             host_wr_en, host_rd_req, host_rd_valid, start, eng_start, eng_done, busy, done;
    logic [1:0]       host_wr_mat;
    logic [SW-1:0]    host_bank;
    logic [AW-1:0]    host_addr;
    logic [W-1:0]     host_wdata, host_rd_data;
    logic [NR*AW-1:0] eng_a_addr;
    logic [NR*W-1:0]  eng_a_data, eng_c_data;
    logic [NC*AW-1:0] eng_b_addr;
    logic [NC*W-1:0]  eng_b_data;
    logic [NR-1:0]    eng_c_valid;
    logic [2:0]       err_flags;

    logic               p_host_wr_en, p_host_rd_req, p_host_rd_valid, p_start, p_eng_start, p_eng_done, p_busy, p_done;
    logic [1:0]         p_host_wr_mat;
    logic [SW-1:0]      p_host_bank;
    logic [AW1-1:0]     p_host_addr;
    logic [W-1:0]       p_host_wdata, p_host_rd_data;
    logic [NR1*AW1-1:0] p_eng_a_addr;
    logic [NR1*W-1:0]   p_eng_a_data, p_eng_c_data;
    logic [NC1*AW1-1:0] p_eng_b_addr;
    logic [NC1*W-1:0]   p_eng_b_data;
    logic [NR1-1:0]     p_eng_c_valid;
    logic [2:0]         p_err_flags;

    matmul_tile_buffer_ctrl #(.DWIDTH(8), .BB_SIZE(32), .AWIDTH(AW), .NUM_ROWS(NR), .NUM_COLS(NC), .SELW(SW)) dut (
        .clk(clk), .reset(reset), .host_wr_en(host_wr_en), .host_wr_mat(host_wr_mat),
        .host_bank(host_bank), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rd_req(host_rd_req), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
        .start(start), .eng_start(eng_start), .eng_done(eng_done),
        .eng_a_addr(eng_a_addr), .eng_a_data(eng_a_data), .eng_b_addr(eng_b_addr), .eng_b_data(eng_b_data),
        .eng_c_valid(eng_c_valid), .eng_c_data(eng_c_data), .busy(busy), .done(done), .err_flags(err_flags)
    );

    matmul_tile_buffer_ctrl #(.DWIDTH(8), .BB_SIZE(32), .AWIDTH(AW1), .NUM_ROWS(NR1), .NUM_COLS(NC1), .SELW(SW)) dut_p (
        .clk(clk), .reset(reset), .host_wr_en(p_host_wr_en), .host_wr_mat(p_host_wr_mat),
        .host_bank(p_host_bank), .host_addr(p_host_addr), .host_wdata(p_host_wdata),
        .host_rd_req(p_host_rd_req), .host_rd_valid(p_host_rd_valid), .host_rd_data(p_host_rd_data),
        .start(p_start), .eng_start(p_eng_start), .eng_done(p_eng_done),
        .eng_a_addr(p_eng_a_addr), .eng_a_data(p_eng_a_data), .eng_b_addr(p_eng_b_addr), .eng_b_data(p_eng_b_data),
        .eng_c_valid(p_eng_c_valid), .eng_c_data(p_eng_c_data), .busy(p_busy), .done(p_done), .err_flags(p_err_flags)
    );

    // Cycle counter used to time-stamp scoreboard entries.
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Scoreboard for the default instance's host readback port.
    always @(negedge clk) begin
        if (host_rd_valid) begin
            n_cmp++;
            if (sb0.size() == 0) begin
                n_bad++;
                $display("FAIL rd0_unexpected: valid with data %h at cycle %0d, required no valid", host_rd_data, cyc_n);
            end else begin
                e0 = sb0.pop_front();
                if (host_rd_data !== e0.data || cyc_n !== e0.due) begin
                    n_bad++;
                    $display("FAIL rd0_word: got %h at cycle %0d, required %h at cycle %0d", host_rd_data, cyc_n, e0.data, e0.due);
                end
            end
        end else if (sb0.size() > 0 && sb0[0].due < cyc_n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd0_missing: no valid by cycle %0d, required %h at cycle %0d", cyc_n, sb0[0].data, sb0[0].due);
            void'(sb0.pop_front());
        end
    end

    // Scoreboard for the 4x3 instance's host readback port.
    always @(negedge clk) begin
        if (p_host_rd_valid) begin
            n_cmp++;
            if (sb1.size() == 0) begin
                n_bad++;
                $display("FAIL rd1_unexpected: valid with data %h at cycle %0d, required no valid", p_host_rd_data, cyc_n);
            end else begin
                e1 = sb1.pop_front();
                if (p_host_rd_data !== e1.data || cyc_n !== e1.due) begin
                    n_bad++;
                    $display("FAIL rd1_word: got %h at cycle %0d, required %h at cycle %0d", p_host_rd_data, cyc_n, e1.data, e1.due);
                end
            end
        end else if (sb1.size() > 0 && sb1[0].due < cyc_n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd1_missing: no valid by cycle %0d, required %h at cycle %0d", cyc_n, sb1[0].data, sb1[0].due);
            void'(sb1.pop_front());
        end
    end

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic logic [W-1:0] wd(input int unsigned i);
        logic [31:0] t;
        t = 32'(i) ^ 32'hC0DE_0000;
        return {8{t}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        host_wr_en = 1'b0; host_wr_mat = '0; host_bank = '0; host_addr = '0; host_wdata = '0;
        host_rd_req = 1'b0; start = 1'b0; eng_done = 1'b0; eng_a_addr = '0; eng_b_addr = '0;
        eng_c_valid = '0; eng_c_data = '0;
        p_host_wr_en = 1'b0; p_host_wr_mat = '0; p_host_bank = '0; p_host_addr = '0; p_host_wdata = '0;
        p_host_rd_req = 1'b0; p_start = 1'b0; p_eng_done = 1'b0; p_eng_a_addr = '0; p_eng_b_addr = '0;
        p_eng_c_valid = '0; p_eng_c_data = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic host_write(input logic [1:0] mat, input int unsigned bank, input int unsigned addr, input logic [W-1:0] data);
        host_wr_en = 1'b1; host_wr_mat = mat; host_bank = SW'(bank); host_addr = AW'(addr); host_wdata = data;
        cyc();
        host_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL reset_err: got %b want 000", err_flags); end
        n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        n_cmp++; if (eng_a_data !== '0) begin n_bad++; $display("FAIL reset_eng_a_data: got %h want 0", eng_a_data); end
        n_cmp++; if (host_rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", host_rd_data); end
    endtask

    task automatic test_engine_read();
        host_write(2'd0, 1, 5, rep(8'hA5));
        host_write(2'd0, 1, 6, rep(8'h66));
        host_write(2'd0, 0, 5, rep(8'h11));
        host_write(2'd1, 0, 3, rep(8'h3C));
        host_write(2'd1, 1, 3, rep(8'h77));
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL eng_start_pulse: got %b want 1", eng_start); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %b want 1", busy); end
        eng_a_addr = {7'd5, 7'd5};
        eng_b_addr = {7'd3, 7'd3};
        cyc();
        n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL eng_start_single: got %b want 0", eng_start); end
        n_cmp++; if (eng_a_data[W +: W] === rep(8'hA5)) begin n_bad++; $display("FAIL a_latency: got %h one cycle early, want it after two", eng_a_data[W +: W]); end
        cyc();
        n_cmp++; if (eng_a_data[W +: W] !== rep(8'hA5)) begin n_bad++; $display("FAIL a1_read: got %h want %h", eng_a_data[W +: W], rep(8'hA5)); end
        n_cmp++; if (eng_a_data[0 +: W] !== rep(8'h11)) begin n_bad++; $display("FAIL a0_read: got %h want %h", eng_a_data[0 +: W], rep(8'h11)); end
        n_cmp++; if (eng_b_data[0 +: W] !== rep(8'h3C)) begin n_bad++; $display("FAIL b0_read: got %h want %h", eng_b_data[0 +: W], rep(8'h3C)); end
        n_cmp++; if (eng_b_data[W +: W] !== rep(8'h77)) begin n_bad++; $display("FAIL b1_read: got %h want %h", eng_b_data[W +: W], rep(8'h77)); end
        eng_a_addr = {7'd6, 7'd5};
        cyc();
        cyc();
        n_cmp++; if (eng_a_data[W +: W] !== rep(8'h66)) begin n_bad++; $display("FAIL a1_read_addr6: got %h want %h", eng_a_data[W +: W], rep(8'h66)); end
    endtask

    // Continues the run started by test_engine_read.
    task automatic test_c_capture();
        for (int i = 0; i < 4; i++) begin
            eng_c_valid = {(i < 2) ? 1'b1 : 1'b0, 1'b1};
            eng_c_data  = {rep(8'h80 + 8'(i)), rep(8'h40 + 8'(i))};
            eng_done    = (i == 3);
            cyc();
        end
        eng_c_valid = '0;
        eng_done    = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL finish_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL finish_busy: got %b want 1", busy); end
        cyc();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_single: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        for (int i = 0; i < 6; i++) begin
            host_rd_req = 1'b1;
            host_bank   = (i < 4) ? SW'(0) : SW'(1);
            host_addr   = (i < 4) ? AW'(i) : AW'(i - 4);
            sb0.push_back('{data: (i < 4) ? rep(8'h40 + 8'(i)) : rep(8'h80 + 8'(i - 4)), due: cyc_n + 2});
            cyc();
        end
        host_rd_req = 1'b0;
        repeat (4) cyc();
        n_cmp++; if (sb0.size() !== 0) begin n_bad++; $display("FAIL capture_drain: got %0d pending want 0", sb0.size()); end
        n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL capture_err: got %b want 000", err_flags); end
    endtask

    task automatic test_errors();
        do_reset();
        host_rd_req = 1'b1; host_bank = SW'(2); host_addr = '0;
        cyc();
        host_rd_req = 1'b0;
        repeat (3) cyc();
        n_cmp++; if (err_flags !== 3'b001) begin n_bad++; $display("FAIL err_rd_bank: got %b want 001", err_flags); end

        do_reset();
        host_write(2'd1, 2, 0, rep(8'hBB));
        n_cmp++; if (err_flags !== 3'b001) begin n_bad++; $display("FAIL err_b_bank: got %b want 001", err_flags); end

        do_reset();
        eng_c_valid = 2'b11;
        cyc();
        eng_c_valid = '0;
        n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL err_idle_valid: got %b want 000", err_flags); end
        host_write(2'd2, 1, 5, rep(8'hEE));
        n_cmp++; if (err_flags !== 3'b001) begin n_bad++; $display("FAIL err_mat2: got %b want 001", err_flags); end

        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        host_write(2'd0, 1, 5, rep(8'hDD));
        n_cmp++; if (err_flags !== 3'b001) begin n_bad++; $display("FAIL err_run_write: got %b want 001", err_flags); end
        eng_done = 1'b1;
        cyc();
        eng_done = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        eng_a_addr = {7'd5, 7'd0};
        cyc();
        cyc();
        n_cmp++; if (eng_a_data[W +: W] !== rep(8'hA5)) begin n_bad++; $display("FAIL a1_unchanged: got %h want %h", eng_a_data[W +: W], rep(8'hA5)); end
        eng_done = 1'b1;
        cyc();
        eng_done = 1'b0;
        cyc();
    endtask

    task automatic test_start_while_busy();
        do_reset();
        start = 1'b1;
        cyc();
        n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL sb_first_pulse: got %b want 1", eng_start); end
        cyc();
        start = 1'b0;
        n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL sb_no_second_pulse: got %b want 0", eng_start); end
        n_cmp++; if (err_flags !== 3'b100) begin n_bad++; $display("FAIL sb_err: got %b want 100", err_flags); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_busy: got %b want 0", busy); end
        n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL midrun_reset_err: got %b want 000", err_flags); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL rerun_pulse: got %b want 1", eng_start); end
        eng_a_addr = {7'd5, 7'd0};
        cyc();
        cyc();
        n_cmp++; if (eng_a_data[W +: W] !== rep(8'hA5)) begin n_bad++; $display("FAIL rerun_a1: got %h want %h", eng_a_data[W +: W], rep(8'hA5)); end
        eng_done = 1'b1;
        cyc();
        eng_done = 1'b0;
        cyc();
    endtask

    task automatic test_c_overflow();
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 129; i++) begin
            eng_c_valid = 2'b01;
            eng_c_data  = {rep(8'h00), wd(i)};
            cyc();
            if (i == 127) begin
                n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL ovf_at_full: got %b want 000", err_flags); end
            end
        end
        eng_c_valid = '0;
        n_cmp++; if (err_flags !== 3'b010) begin n_bad++; $display("FAIL ovf_err: got %b want 010", err_flags); end
        eng_done = 1'b1;
        cyc();
        eng_done = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            host_rd_req = 1'b1;
            host_bank   = '0;
            host_addr   = (k == 0) ? AW'(0) : (k == 1) ? AW'(127) : AW'(1);
            sb0.push_back('{data: (k == 0) ? wd(0) : (k == 1) ? wd(127) : wd(1), due: cyc_n + 2});
            cyc();
        end
        host_rd_req = 1'b0;
        repeat (4) cyc();
        n_cmp++; if (sb0.size() !== 0) begin n_bad++; $display("FAIL ovf_drain: got %0d pending want 0", sb0.size()); end
    endtask

    task automatic test_param_sweep();
        do_reset();
        p_host_wr_en = 1'b1; p_host_wr_mat = 2'd1; p_host_bank = SW'(3); p_host_addr = '0; p_host_wdata = rep(8'hBB);
        cyc();
        p_host_wr_en = 1'b0;
        n_cmp++; if (p_err_flags !== 3'b001) begin n_bad++; $display("FAIL p_b3_reject: got %b want 001", p_err_flags); end
        do_reset();
        for (int k = 0; k < 2; k++) begin
            p_host_wr_en = 1'b1; p_host_wr_mat = 2'd0; p_host_bank = (k == 0) ? SW'(3) : SW'(0);
            p_host_addr = AW1'(2); p_host_wdata = (k == 0) ? rep(8'hB3) : rep(8'hB0);
            cyc();
        end
        p_host_wr_en = 1'b0;
        n_cmp++; if (p_err_flags !== 3'b000) begin n_bad++; $display("FAIL p_a_write_err: got %b want 000", p_err_flags); end
        p_start = 1'b1;
        cyc();
        p_start = 1'b0;
        n_cmp++; if (p_eng_start !== 1'b1) begin n_bad++; $display("FAIL p_eng_start: got %b want 1", p_eng_start); end
        p_eng_a_addr = {4'd2, 4'd0, 4'd0, 4'd2};
        cyc();
        cyc();
        n_cmp++; if (p_eng_a_data[3*W +: W] !== rep(8'hB3)) begin n_bad++; $display("FAIL p_a3_read: got %h want %h", p_eng_a_data[3*W +: W], rep(8'hB3)); end
        n_cmp++; if (p_eng_a_data[0 +: W] !== rep(8'hB0)) begin n_bad++; $display("FAIL p_a0_read: got %h want %h", p_eng_a_data[0 +: W], rep(8'hB0)); end
        for (int i = 0; i < 17; i++) begin
            p_eng_c_valid = 4'b1000;
            p_eng_c_data  = {wd(300 + i), {(3 * W){1'b0}}};
            cyc();
            if (i == 15) begin
                n_cmp++; if (p_err_flags !== 3'b000) begin n_bad++; $display("FAIL p_ovf_at_full: got %b want 000", p_err_flags); end
            end
        end
        p_eng_c_valid = '0;
        n_cmp++; if (p_err_flags !== 3'b010) begin n_bad++; $display("FAIL p_ovf_err: got %b want 010", p_err_flags); end
        p_eng_done = 1'b1;
        cyc();
        p_eng_done = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            p_host_rd_req = 1'b1;
            p_host_bank   = SW'(3);
            p_host_addr   = (k == 0) ? AW1'(0) : AW1'(15);
            sb1.push_back('{data: (k == 0) ? wd(300) : wd(315), due: cyc_n + 2});
            cyc();
        end
        p_host_rd_req = 1'b0;
        repeat (4) cyc();
        n_cmp++; if (sb1.size() !== 0) begin n_bad++; $display("FAIL p_drain: got %0d pending want 0", sb1.size()); end
    endtask

    initial begin
        test_reset();
        test_engine_read();
        test_c_capture();
        test_errors();
        test_start_while_busy();
        test_c_overflow();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
